// File: rtl/result_checker_if.sv
// Result-pair and verdict signals of the dual-multiplier result checker.
// Handshake: valid stays high with a stable verdict until the consumer drives ack=1 on a clock edge; ack while valid=0 is ignored.
interface result_checker_if #(
    parameter int CNT_W = 16
);
    logic             done;
    logic [31:0]      res;
    logic             ack;
    logic             clr_stats;
    logic             valid;
    logic             match;
    logic [31:0]      res_out;
    logic [31:0]      diff;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] mism_cnt;
    logic             overrun;
    logic             proto_err;

    modport master (
        output done, res, ack, clr_stats,
        input  valid, match, res_out, diff, total_cnt, mism_cnt, overrun, proto_err
    );

    modport slave (
        input  done, res, ack, clr_stats,
        output valid, match, res_out, diff, total_cnt, mism_cnt, overrun, proto_err
    );
endinterface

// File: rtl/result_checker.sv
// Compares result A and result B of a two-cycle done strobe and keeps match statistics.
// Optional macro RESULT_CHECKER_NAN_EQUIV_EN: any two NaNs compare equal.
module result_checker #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    result_checker_if.slave   bus,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAP_B = 2'd1,
        CMP   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state, state_nxt;
    logic        prev_done;
    logic        fresh;
    logic [31:0] a_q, b_q;
    logic        rise;
    logic        match_c;
    logic        cap_a, cap_b, do_cmp, set_proto, set_ovr, release_v;

    // fresh masks the first edge after reset so a done already high is not a rising edge
    assign rise      = bus.done & ~prev_done & ~fresh;
    assign state_dbg = state;

`ifdef RESULT_CHECKER_NAN_EQUIV_EN
    logic a_nan, b_nan;
    assign a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    assign match_c = (a_q == b_q) || (a_nan && b_nan);
`else
    assign match_c = (a_q == b_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        do_cmp    = 1'b0;
        set_proto = 1'b0;
        set_ovr   = 1'b0;
        release_v = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    cap_a     = 1'b1;
                    state_nxt = CAP_B;
                end
            end
            CAP_B: begin
                if (bus.done) begin
                    cap_b     = 1'b1;
                    state_nxt = CMP;
                end else begin
                    set_proto = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CMP: begin
                do_cmp    = 1'b1;
                set_ovr   = rise;
                state_nxt = HOLD;
            end
            HOLD: begin
                set_ovr = rise;
                if (bus.ack) begin
                    release_v = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_done   <= 1'b0;
            fresh       <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            bus.valid   <= 1'b0;
            bus.match   <= 1'b0;
            bus.res_out <= '0;
            bus.diff    <= '0;
        end else begin
            prev_done <= bus.done;
            fresh     <= 1'b0;
            if (cap_a) a_q <= bus.res;
            if (cap_b) b_q <= bus.res;
            if (do_cmp) begin
                bus.valid   <= 1'b1;
                bus.match   <= match_c;
                bus.diff    <= a_q ^ b_q;
                bus.res_out <= a_q;
            end else if (release_v) begin
                bus.valid <= 1'b0;
            end
        end
    end

    // Statistics: clr_stats takes priority over any increment or flag set in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.total_cnt <= '0;
            bus.mism_cnt  <= '0;
            bus.overrun   <= 1'b0;
            bus.proto_err <= 1'b0;
        end else if (bus.clr_stats) begin
            bus.total_cnt <= '0;
            bus.mism_cnt  <= '0;
            bus.overrun   <= 1'b0;
            bus.proto_err <= 1'b0;
        end else begin
            if (do_cmp && bus.total_cnt != CNT_MAX)
                bus.total_cnt <= bus.total_cnt + 1'b1;
            if (do_cmp && !match_c && bus.mism_cnt != CNT_MAX)
                bus.mism_cnt <= bus.mism_cnt + 1'b1;
            if (set_ovr)   bus.overrun   <= 1'b1;
            if (set_proto) bus.proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// Randomized bench for result_checker against a transaction-level reference model.
// Small counter width so saturation is reached quickly.
module tb_result_checker;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  result_checker_if #(.CNT_W(CNT_W)) bus ();

  result_checker #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard and model state
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [64:0] exp_q[$];
  int exp_total = 0;
  int exp_mism  = 0;
  bit exp_ovr   = 1'b0;
  bit exp_proto = 1'b0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // expected verdict {match, diff, res_out}
  function automatic logic [64:0] ref_verdict(input logic [31:0] a, input logic [31:0] b);
    logic m;
    m = (a == b);
`ifdef RESULT_CHECKER_NAN_EQUIV_EN
    if (is_nan(a) && is_nan(b)) m = 1'b1;
`endif
    return {m, a ^ b, a};
  endfunction

  function automatic logic [64:0] verdict_now();
    return {bus.match, bus.diff, bus.res_out};
  endfunction

  task automatic check_stats(input string tag);
    check({tag, "_total"},   65'(bus.total_cnt), 65'(exp_total));
    check({tag, "_mism"},    65'(bus.mism_cnt),  65'(exp_mism));
    check({tag, "_overrun"}, 65'(bus.overrun),   65'(exp_ovr));
    check({tag, "_proto"},   65'(bus.proto_err), 65'(exp_proto));
  endtask

  // driver: one full transaction, entered and left at a negedge with done low
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit clr, input bit ovr);
    logic [64:0] v;
    exp_q.push_back(ref_verdict(a, b));
    bus.done = 1'b1;
    bus.res  = a;
    @(negedge clk);
    bus.res = b;
    @(negedge clk);
    bus.done      = 1'b0;
    bus.res       = $urandom;
    bus.clr_stats = clr;
    check("lat_early", 65'(bus.valid), 65'(0));
    @(negedge clk);
    bus.clr_stats = 1'b0;
    v = exp_q.pop_front();
    if (clr) begin
      exp_total = 0;
      exp_mism  = 0;
      exp_ovr   = 1'b0;
      exp_proto = 1'b0;
    end else begin
      if (exp_total < CNT_MAX) exp_total++;
      if (!v[64] && exp_mism < CNT_MAX) exp_mism++;
    end
    check("lat_valid", 65'(bus.valid), 65'(1));
    check("verdict", verdict_now(), v);
    check_stats("cmp");
    if (ovr) begin
      bus.done = 1'b1;
      bus.res  = $urandom;
      @(negedge clk);
      bus.res = $urandom;
      @(negedge clk);
      bus.done = 1'b0;
      exp_ovr  = 1'b1;
      @(negedge clk);
      check("ovr_valid", 65'(bus.valid), 65'(1));
      check("ovr_verdict", verdict_now(), v);
      check_stats("ovr");
    end
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 65'(bus.valid), 65'(1));
      check("hold_verdict", verdict_now(), v);
    end
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    check("ack_clear", 65'(bus.valid), 65'(0));
    check_stats("ack");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 65'(bus.valid), 65'(0));
    check({tag, "_verdict"}, verdict_now(), 65'(0));
    check_stats(tag);
  endtask

  initial begin
    logic [31:0] a, b;
    rst           = 1'b1;
    bus.done      = 1'b0;
    bus.res       = '0;
    bus.ack       = 1'b0;
    bus.clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // equal operands, then a one-bit mismatch held for 5 cycles, then NaN pair
    run_txn(32'h40C0_0000, 32'h40C0_0000, 0, 1'b0, 1'b0);
    run_txn(32'h40C0_0000, 32'h40C0_0001, 5, 1'b0, 1'b0);
    run_txn(32'h7FC0_0000, 32'hFFC0_0001, 1, 1'b0, 1'b0);

    // ack with nothing pending has no effect
    bus.ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_ack_valid", 65'(bus.valid), 65'(0));
    end
    bus.ack = 1'b0;
    @(negedge clk);
    run_txn($urandom, $urandom, 0, 1'b0, 1'b0);

    // single-cycle done
    bus.done = 1'b1;
    bus.res  = $urandom;
    @(negedge clk);
    bus.done  = 1'b0;
    exp_proto = 1'b1;
    @(negedge clk);
    check_stats("proto");
    repeat (3) begin
      @(negedge clk);
      check("proto_no_valid", 65'(bus.valid), 65'(0));
    end

    // transaction arriving during HOLD is dropped, next one is normal
    run_txn(32'h1234_5678, 32'h1234_5678, 2, 1'b0, 1'b1);
    run_txn(32'h0000_0001, 32'h8000_0001, 1, 1'b0, 1'b0);

    // clear coincident with CMP wipes counters and sticky flags
    run_txn(32'hDEAD_BEEF, 32'hDEAD_BEEE, 1, 1'b1, 1'b0);

    // random traffic, long enough to saturate the counters
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (32'd1 << $urandom_range(0, 31));
        2: begin
          a = {a[31], 8'hFF, a[22:1], 1'b1};
          b = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom) | 23'd4};
        end
        default: b = $urandom;
      endcase
      run_txn(a, b, $urandom_range(0, 3), ($urandom_range(0, 15) == 0), 1'b0);
    end

    // reset while in CAP_B, done held high across reset release
    bus.done = 1'b1;
    bus.res  = 32'hCAFE_F00D;
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_total = 0;
    exp_mism  = 0;
    exp_ovr   = 1'b0;
    exp_proto = 1'b0;
    check_all_zero("rst_capb");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_done_high_valid", 65'(bus.valid), 65'(0));
    end
    bus.done = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("rst_settled");
    run_txn(32'h3F80_0000, 32'h3F80_0000, 1, 1'b0, 1'b0);

    check("scoreboard_empty", 65'(exp_q.size()), 65'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the transaction and mismatch counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port done  input  1  result-pair strobe from the dual-multiplier stage; high exactly two consecutive cycles per transaction.
REQ-005 SHALL have port res  input  32  result bus; first done cycle carries result A (Verilog unit), second carries result B (VHDL unit).
REQ-006 SHALL have port ack  input  1  consumer acknowledge of the current verdict.
REQ-007 SHALL have port clr_stats  input  1  synchronous clear of counters and sticky flags.
REQ-008 SHALL have port valid  output  1  verdict outputs are valid.
REQ-009 SHALL have port match  output  1  A and B judged equal.
REQ-010 SHALL have port res_out  output  32  captured result A.
REQ-011 SHALL have port diff  output  32  A XOR B.
REQ-012 SHALL have port total_cnt  output  CNT_W  completed transactions.
REQ-013 SHALL have port mism_cnt  output  CNT_W  mismatching transactions.
REQ-014 SHALL have port overrun  output  1  sticky: transaction dropped while busy.
REQ-015 SHALL have port proto_err  output  1  sticky: done high for only one cycle.

Function
REQ-016 SHALL implement FSM states IDLE, CAP_B, CMP, HOLD.
REQ-017 IDLE: on the edge at which done=1 and the registered previous done=0, SHALL capture res into A and go to CAP_B.
REQ-018 CAP_B: if done=1, SHALL capture res into B and go to CMP; if done=0, SHALL set proto_err, discard A and go to IDLE.
REQ-019 CMP: SHALL register match, diff, res_out=A, set valid=1, increment total_cnt, increment mism_cnt if match=0, and go to HOLD.
REQ-020 Latency SHALL be fixed: valid rises two edges after the edge capturing A.
REQ-021 HOLD: valid, match, res_out and diff SHALL be held stable until an edge with ack=1, at which valid clears and the FSM returns to IDLE.
REQ-022 ack while valid=0 SHALL be ignored.
REQ-023 A done rising edge seen in CMP or HOLD SHALL set overrun and be dropped entirely, including its second cycle.
REQ-024 Equality SHALL be exact 32-bit equality, except as modified by REQ-031.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 clr_stats SHALL zero total_cnt, mism_cnt, overrun and proto_err; if it coincides with an increment or a flag set, the clear SHALL win; FSM and verdict are unaffected.

Reset
REQ-027 rst SHALL immediately force the FSM to IDLE and set valid=0, match=0, res_out=0, diff=0, total_cnt=0, mism_cnt=0, overrun=0, proto_err=0, and the previous-done register=0.
REQ-028 rst asserted mid-transaction SHALL abandon it without a counter update.
REQ-029 After rst deasserts, done already high SHALL NOT be treated as a rising edge.

Configuration
REQ-030 SHALL use macro RESULT_CHECKER_NAN_EQUIV_EN.
REQ-031 When the macro is defined: if A and B are both NaN (exponent 0xFF, mantissa nonzero), match SHALL be 1 regardless of sign or payload; diff still reports A XOR B.
REQ-032 When the macro is undefined: NaNs SHALL compare bit-exactly per REQ-024.

Verification
REQ-033 done pulsed 2 cycles with res=0x40C00000 then 0x40C00000 -> valid after 2 edges, match=1, diff=0, total_cnt=1, mism_cnt=0.
REQ-034 res=0x40C00000 then 0x40C00001, ack held low 5 cycles -> match=0, diff=0x00000001, mism_cnt=1, outputs stable until ack.
REQ-035 res=0x7FC00000 then 0xFFC00001 -> with macro defined match=1; with macro undefined match=0 and mism_cnt=1.
REQ-036 Second transaction started during HOLD -> overrun=1, total_cnt unchanged; then ack followed by a new transaction -> processed normally.
REQ-037 done high for a single cycle -> proto_err=1, no valid; rst asserted in CAP_B -> all outputs 0; clr_stats coincident with CMP -> counters 0.
